// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b memory port arbiter: line type, FSM states and requester sides.
package mem_arbiter_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic [0:0] {
    ARB_INST = 1'b0,
    ARB_DATA = 1'b1
  } arb_side_t;

  // Round-robin choice when both sides are pending: serve whoever did not go last.
  function automatic arb_state_t rr_pick(input arb_side_t last_grant);
    rr_pick = (last_grant == ARB_DATA) ? ARB_SERVE_I : ARB_SERVE_D;
  endfunction

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer used for the arbiter's port steering.
module mux2 #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] f
);

  assign f = sel ? b : a;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single physical memory port between the I-cache miss path and
// the D-cache miss/writeback path, returning each response only to its owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_W_P = LINE_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_read,
  input  logic [ADDR_W_P-1:0] i_address,
  output logic [LINE_W_P-1:0] i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W_P-1:0] d_address,
  input  logic [LINE_W_P-1:0] d_wdata,
  output logic [LINE_W_P-1:0] d_rdata,
  output logic                d_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W_P-1:0] pmem_address,
  output logic [LINE_W_P-1:0] pmem_wdata,
  input  logic [LINE_W_P-1:0] pmem_rdata,
  input  logic                pmem_resp
);

  arb_state_t state_q, state_d;
  arb_side_t  last_q, last_d;

  logic i_pend_s, d_pend_s;
  logic serve_i_s, serve_d_s, busy_s;

  logic [ADDR_W_P-1:0] addr_sel_s;
  logic [ADDR_W_P-1:0] addr_zero_s;
  logic [LINE_W_P-1:0] line_zero_s;

  assign i_pend_s    = i_read;
  assign d_pend_s    = d_read | d_write;
  assign serve_i_s   = (state_q == ARB_SERVE_I);
  assign serve_d_s   = (state_q == ARB_SERVE_D);
  assign busy_s      = serve_i_s | serve_d_s;
  assign addr_zero_s = '0;
  assign line_zero_s = '0;

  // State and last-grant registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_DATA;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: grant in IDLE, hold the grant until memory answers.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_pend_s && d_pend_s) begin
          state_d = rr_pick(last_q);
        end else if (i_pend_s) begin
          state_d = ARB_SERVE_I;
        end else if (d_pend_s) begin
          state_d = ARB_SERVE_D;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_SERVE_I: begin
        if (pmem_resp) begin
          state_d = ARB_IDLE;
          last_d  = ARB_INST;
        end else begin
          state_d = ARB_SERVE_I;
        end
      end
      ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_d = ARB_IDLE;
          last_d  = ARB_DATA;
        end else begin
          state_d = ARB_SERVE_D;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        last_d  = last_q;
      end
    endcase
  end

  // Address: pick the granted side, then force zero while idle.
  mux2 #(.W(ADDR_W_P)) u_addr_side (
    .sel (serve_d_s),
    .a   (i_address),
    .b   (d_address),
    .f   (addr_sel_s)
  );

  mux2 #(.W(ADDR_W_P)) u_addr_gate (
    .sel (busy_s),
    .a   (addr_zero_s),
    .b   (addr_sel_s),
    .f   (pmem_address)
  );

  mux2 #(.W(LINE_W_P)) u_wdata (
    .sel (serve_d_s),
    .a   (line_zero_s),
    .b   (d_wdata),
    .f   (pmem_wdata)
  );

  mux2 #(.W(LINE_W_P)) u_irdata (
    .sel (serve_i_s),
    .a   (line_zero_s),
    .b   (pmem_rdata),
    .f   (i_rdata)
  );

  mux2 #(.W(LINE_W_P)) u_drdata (
    .sel (serve_d_s),
    .a   (line_zero_s),
    .b   (pmem_rdata),
    .f   (d_rdata)
  );

  // Strobes track the granted requester live; a simultaneous read+write is treated as a write.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      ARB_SERVE_I: begin
        pmem_read = i_read;
        i_resp    = pmem_resp;
      end
      ARB_SERVE_D: begin
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        d_resp     = pmem_resp;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, lone and shared grants,
// writes, fairness, dropped requests and stray responses.
module tb_mem_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_cmp;
  int n_err;

  localparam logic [127:0] PAT_A5 = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] PAT_3C = 128'h3C3C_0000_1111_2222_3333_4444_5555_6666;

  mem_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    step();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    i_read = 1'b0; i_address = 16'h0000;
    d_read = 1'b0; d_write = 1'b0; d_address = 16'h0000; d_wdata = 128'h0;
    pmem_rdata = 128'h0; pmem_resp = 1'b0;
    step();
    step();
    chk("rst_pmem_read", {127'h0, pmem_read}, 128'h0);
    chk("rst_pmem_write", {127'h0, pmem_write}, 128'h0);
    chk("rst_pmem_addr", {112'h0, pmem_address}, 128'h0);
    reset_n = 1'b1;
    #1;

    // Lone ifetch
    i_read = 1'b1; i_address = 16'h1230;
    #1;
    chk("lone_i_idle_read", {127'h0, pmem_read}, 128'h0);
    step();
    chk("lone_i_read", {127'h0, pmem_read}, 128'h1);
    chk("lone_i_write", {127'h0, pmem_write}, 128'h0);
    chk("lone_i_addr", {112'h0, pmem_address}, 128'h1230);
    chk("lone_i_wdata", pmem_wdata, 128'h0);
    pmem_resp = 1'b1; pmem_rdata = PAT_A5;
    #1;
    chk("lone_i_resp", {127'h0, i_resp}, 128'h1);
    chk("lone_i_rdata", i_rdata, PAT_A5);
    chk("lone_i_dresp", {127'h0, d_resp}, 128'h0);
    chk("lone_i_drdata", d_rdata, 128'h0);
    step();
    i_read = 1'b0; pmem_resp = 1'b0;
    #1;
    chk("lone_i_bubble_read", {127'h0, pmem_read}, 128'h0);
    chk("lone_i_bubble_resp", {127'h0, i_resp}, 128'h0);

    // Simultaneous reads from reset: I first
    do_reset();
    i_read = 1'b1; i_address = 16'h0AA0;
    d_read = 1'b1; d_address = 16'h0BB0;
    step();
    chk("sim_first_addr", {112'h0, pmem_address}, 128'h0AA0);
    chk("sim_first_read", {127'h0, pmem_read}, 128'h1);
    pmem_resp = 1'b1; pmem_rdata = PAT_3C;
    #1;
    chk("sim_first_iresp", {127'h0, i_resp}, 128'h1);
    chk("sim_first_dresp", {127'h0, d_resp}, 128'h0);
    step();
    i_read = 1'b0; pmem_resp = 1'b0;
    #1;
    chk("sim_bubble_read", {127'h0, pmem_read}, 128'h0);
    chk("sim_bubble_addr", {112'h0, pmem_address}, 128'h0);
    step();
    chk("sim_second_addr", {112'h0, pmem_address}, 128'h0BB0);
    chk("sim_second_read", {127'h0, pmem_read}, 128'h1);
    chk("sim_second_dresp_pre", {127'h0, d_resp}, 128'h0);
    pmem_resp = 1'b1; pmem_rdata = PAT_A5;
    #1;
    chk("sim_second_dresp", {127'h0, d_resp}, 128'h1);
    chk("sim_second_drdata", d_rdata, PAT_A5);
    chk("sim_second_iresp", {127'h0, i_resp}, 128'h0);
    step();
    d_read = 1'b0; pmem_resp = 1'b0;
    #1;

    // Write with an ifetch arriving mid-write
    d_write = 1'b1; d_address = 16'h4000; d_wdata = 128'h1;
    step();
    chk("wr_write", {127'h0, pmem_write}, 128'h1);
    chk("wr_read", {127'h0, pmem_read}, 128'h0);
    chk("wr_addr", {112'h0, pmem_address}, 128'h4000);
    chk("wr_wdata", pmem_wdata, 128'h1);
    i_read = 1'b1; i_address = 16'h1230;
    step();
    chk("wr_hold_write", {127'h0, pmem_write}, 128'h1);
    chk("wr_hold_addr", {112'h0, pmem_address}, 128'h4000);
    pmem_resp = 1'b1;
    #1;
    chk("wr_dresp", {127'h0, d_resp}, 128'h1);
    chk("wr_iresp", {127'h0, i_resp}, 128'h0);
    step();
    d_write = 1'b0; pmem_resp = 1'b0;
    #1;
    chk("wr_bubble_read", {127'h0, pmem_read}, 128'h0);
    chk("wr_bubble_write", {127'h0, pmem_write}, 128'h0);
    step();
    chk("wr_then_i_read", {127'h0, pmem_read}, 128'h1);
    chk("wr_then_i_addr", {112'h0, pmem_address}, 128'h1230);
    chk("wr_then_i_wdata", pmem_wdata, 128'h0);

    // Granted ifetch drops its request: strobe follows, resp still pulses
    i_read = 1'b0;
    #1;
    chk("drop_read", {127'h0, pmem_read}, 128'h0);
    step();
    chk("drop_wait_read", {127'h0, pmem_read}, 128'h0);
    pmem_resp = 1'b1; pmem_rdata = PAT_3C;
    #1;
    chk("drop_iresp", {127'h0, i_resp}, 128'h1);
    chk("drop_irdata", i_rdata, PAT_3C);
    step();
    pmem_resp = 1'b0;
    #1;

    // Read and write together: write wins
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h5550; d_wdata = PAT_3C;
    step();
    chk("rw_write", {127'h0, pmem_write}, 128'h1);
    chk("rw_read", {127'h0, pmem_read}, 128'h0);
    chk("rw_wdata", pmem_wdata, PAT_3C);
    pmem_resp = 1'b1;
    #1;
    chk("rw_dresp", {127'h0, d_resp}, 128'h1);
    step();
    d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    #1;

    // Reset mid SERVE_D
    d_read = 1'b1; d_address = 16'h7770;
    step();
    chk("rstmid_pre_read", {127'h0, pmem_read}, 128'h1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_read", {127'h0, pmem_read}, 128'h0);
    chk("rstmid_addr", {112'h0, pmem_address}, 128'h0);
    chk("rstmid_drdata", d_rdata, 128'h0);
    d_read = 1'b0;
    step();
    reset_n = 1'b1;
    #1;

    // Stray pmem_resp in IDLE
    pmem_resp = 1'b1; pmem_rdata = PAT_A5;
    #1;
    chk("stray_iresp", {127'h0, i_resp}, 128'h0);
    chk("stray_dresp", {127'h0, d_resp}, 128'h0);
    chk("stray_irdata", i_rdata, 128'h0);
    step();
    chk("stray_stay_iresp", {127'h0, i_resp}, 128'h0);
    chk("stray_stay_dresp", {127'h0, d_resp}, 128'h0);
    chk("stray_stay_read", {127'h0, pmem_read}, 128'h0);
    pmem_resp = 1'b0;

    // Fairness from reset: I,D,I,D,...
    do_reset();
    i_read = 1'b1; i_address = 16'h1110;
    d_read = 1'b1; d_address = 16'h2220;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("fair_addr_%0d", k), {112'h0, pmem_address},
          (k % 2 == 0) ? 128'h1110 : 128'h2220);
      pmem_resp = 1'b1;
      #1;
      chk($sformatf("fair_iresp_%0d", k), {127'h0, i_resp},
          (k % 2 == 0) ? 128'h1 : 128'h0);
      chk($sformatf("fair_dresp_%0d", k), {127'h0, d_resp},
          (k % 2 == 0) ? 128'h0 : 128'h1);
      step();
      pmem_resp = 1'b0;
      #1;
      chk($sformatf("fair_bubble_%0d", k), {127'h0, pmem_read}, 128'h0);
    end
    i_read = 1'b0; d_read = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
